// File: rtl/control_if.sv
// control_if: bundles the control unit's IR/Stop inputs and all datapath
// control strobes it produces.
//   master : control unit side (takes IR/Stop, drives strobes, Run, count)
//   slave  : datapath side (drives IR/Stop, takes strobes)
interface control_if;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout;
  logic        IRin, Yin, ZLOout, Cout;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  alu_op;
  logic        Run;
  logic [15:0] instr_count;

  modport master (
    input  IR, Stop,
    output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
           IRin, Yin, ZLOout, Cout, Rin, Rout, alu_op, Run, instr_count
  );

  modport slave (
    output IR, Stop,
    input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
           IRin, Yin, ZLOout, Cout, Rin, Rout, alu_op, Run, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer for the register and
// immediate ALU subset. Moore outputs decoded from state plus IR.
//   Clock      : rising-edge clock
//   Reset      : asynchronous active-high reset
//   cu.IR      : instruction register (opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15])
//   cu.Stop    : halt request, taken only at an instruction boundary
//   cu.*       : datapath strobes, one-hot Rin/Rout, alu_op, Run, instr_count
module control_unit #(
  parameter int RESET_PC_WAIT = 1  // 1..4
) (
  input  logic      Clock,
  input  logic      Reset,
  control_if.master cu
);

  typedef enum logic [2:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RESET_PC_WAIT - 1);

  state_t      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [15:0] cnt_q, cnt_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_rfmt, is_imm, is_halt;
  state_t     boundary;  // where an instruction boundary leads

  assign opcode  = cu.IR[31:27];
  assign ra      = cu.IR[26:23];
  assign rb      = cu.IR[22:19];
  assign rc      = cu.IR[18:15];
  assign is_rfmt = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_imm  = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_halt = (opcode == 5'b11011);
  assign boundary = cu.Stop ? S_HALTED : S_T0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and retire counter
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        if (wait_q == WAIT_LAST) state_d = boundary;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_rfmt || is_imm) begin
          state_d = S_T4;
        end else begin
          // nop, halt and unknown opcodes retire here
          state_d = is_halt ? S_HALTED : boundary;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        state_d = boundary;
        cnt_d   = cnt_q + 16'd1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  // Moore output decode; IR is stable from T3 onward
  always_comb begin
    cu.PCout  = 1'b0;
    cu.MARin  = 1'b0;
    cu.IncPC  = 1'b0;
    cu.Zin    = 1'b0;
    cu.PCin   = 1'b0;
    cu.Read   = 1'b0;
    cu.MDRin  = 1'b0;
    cu.MDRout = 1'b0;
    cu.IRin   = 1'b0;
    cu.Yin    = 1'b0;
    cu.ZLOout = 1'b0;
    cu.Cout   = 1'b0;
    cu.Rin    = '0;
    cu.Rout   = '0;
    cu.alu_op = '0;
    cu.Run    = (state_q != S_RESET) && (state_q != S_HALTED);
    case (state_q)
      S_T0: begin
        cu.PCout = 1'b1;
        cu.MARin = 1'b1;
        cu.IncPC = 1'b1;
        cu.Zin   = 1'b1;
      end
      S_T1: begin
        cu.ZLOout = 1'b1;
        cu.PCin   = 1'b1;
        cu.Read   = 1'b1;
        cu.MDRin  = 1'b1;
      end
      S_T2: begin
        cu.MDRout = 1'b1;
        cu.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_rfmt || is_imm) begin
          cu.Rout = 16'h0001 << rb;
          cu.Yin  = 1'b1;
        end
      end
      S_T4: begin
        cu.Zin    = 1'b1;
        cu.alu_op = opcode;
        if (is_imm) cu.Cout = 1'b1;
        else        cu.Rout = 16'h0001 << rc;
      end
      S_T5: begin
        cu.ZLOout = 1'b1;
        cu.Rin    = 16'h0001 << ra;
      end
      default: ;
    endcase
  end

  assign cu.instr_count = cnt_q;

endmodule
